// File: rtl/ahb_params_pkg.sv
// ahb_params_pkg: shared AHB encodings, burst length helper and arbiter state type
package ahb_params_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1,
        HRESP_RETRY = 2'd2,
        HRESP_SPLIT = 2'd3
    } hresp_t;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // Beat count of a fixed-length burst; undefined-length bursts report 0
    function automatic logic [4:0] burst_len(hburst_t b);
        return (b == HBURST_WRAP4  || b == HBURST_INCR4)  ? 5'd4 :
               (b == HBURST_WRAP8  || b == HBURST_INCR8)  ? 5'd8 :
               (b == HBURST_WRAP16 || b == HBURST_INCR16) ? 5'd16 : 5'd0;
    endfunction

endpackage

// File: rtl/ahb_arb_prio_sel.sv
// ahb_arb_prio_sel: rotating priority encoder; mode=0 ignores start_idx (index 0 highest)
module ahb_arb_prio_sel #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start_idx,
    input  logic         mode,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        j      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = k + (mode ? int'(start_idx) : 0);
            if (j >= N) j = j - N;
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = W'(j);
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_param.sv
// ahb_arbiter_param: N-master AHB arbiter with burst/lock protection and SPLIT masking
module ahb_arbiter_param
    import ahb_params_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int ARB_MODE       = 0,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [MW-1:0]          LAST    = MW'(NUM_MASTERS - 1);

    arb_state_t             state, state_nxt;
    logic [4:0]             beats_left, beats_nxt, blen;
    logic [MW-1:0]          gnt_idx, rr_ptr, sel_idx, win_idx;
    logic [NUM_MASTERS-1:0] split_mask, set_mask, eligible, sel_oh, win_oh;
    logic                   err, load, lock_cur, arb_ok, rr_upd;

    ahb_arb_prio_sel #(.N(NUM_MASTERS), .W(MW)) u_sel (
        .req       (eligible),
        .start_idx (rr_ptr),
        .mode      (ARB_MODE != 0),
        .onehot    (sel_oh),
        .idx       (sel_idx)
    );

    // Eligibility, beat accounting and the arbitration-window decision
    always_comb begin
        err       = HREADY && (HRESP != HRESP_OKAY);
        set_mask  = (err && HRESP == HRESP_SPLIT && HMASTER != DEF_IDX) ? NUM_MASTERS'(1) << HMASTER : '0;
        eligible  = HBUSREQ & ~(split_mask | set_mask);
        win_oh    = |eligible ? sel_oh : DEF_OH;
        win_idx   = |eligible ? sel_idx : DEF_IDX;
        lock_cur  = HLOCK[gnt_idx];
        blen      = burst_len(hburst_t'(HBURST));
        load      = HREADY && !err && HTRANS == HTRANS_NONSEQ && blen != 5'd0;
        beats_nxt = !HREADY ? beats_left :
                    err ? 5'd0 :
                    load ? blen - 5'd1 :
                    (HTRANS == HTRANS_SEQ && beats_left != 5'd0) ? beats_left - 5'd1 : beats_left;
        arb_ok    = HREADY && (err ||
                    (state == ST_ARB && !lock_cur) ||
                    (state == ST_BURST && beats_nxt == 5'd1) ||
                    (state == ST_LOCKED && !lock_cur));
        rr_upd    = arb_ok && (|eligible || win_idx != gnt_idx);
    end

    // Next state: errors force ARB, a new owner with HLOCK enters LOCKED, fixed bursts enter BURST
    always_comb begin
        state_nxt = state;
        if (HREADY && err)
            state_nxt = ST_ARB;
        else if (arb_ok)
            state_nxt = HLOCK[win_idx] ? ST_LOCKED : (load ? ST_BURST : ST_ARB);
    end

    // State register and burst beat counter, both frozen by wait states
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_ARB;
            beats_left <= 5'd0;
        end else if (HREADY) begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
        end
    end

    // Grant, round-robin pointer and address-phase owner updates
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANT    <= DEF_OH;
            gnt_idx   <= DEF_IDX;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
            rr_ptr    <= '0;
        end else if (HREADY) begin
            HMASTER   <= gnt_idx;
            HMASTLOCK <= lock_cur;
            if (arb_ok) begin
                HGRANT  <= win_oh;
                gnt_idx <= win_idx;
            end
            if (rr_upd) rr_ptr <= (win_idx == LAST) ? '0 : win_idx + MW'(1);
        end
    end

    // SPLIT mask: releases act even during wait states; a same-edge set beats the release
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) split_mask <= '0;
        else        split_mask <= (split_mask & ~HSPLIT) | set_mask;
    end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// tb_ahb_arbiter_param: directed vector table plus hand sequences for RR and async reset
module tb_ahb_arbiter_param;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [3:0] HBUSREQ = '0, HLOCK = '0, HSPLIT = '0;
    logic [1:0] HTRANS = '0, HRESP = '0;
    logic [2:0] HBURST = '0;
    logic       HREADY = 1'b1;
    logic [3:0] fx_grant, rr_grant;
    logic [1:0] fx_master, rr_master;
    logic       fx_lock, rr_lock;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_param #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .ARB_MODE(0)) dut_fx (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
        .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HSPLIT(HSPLIT),
        .HGRANT(fx_grant), .HMASTER(fx_master), .HMASTLOCK(fx_lock)
    );

    ahb_arbiter_param #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
        .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP), .HSPLIT(HSPLIT),
        .HGRANT(rr_grant), .HMASTER(rr_master), .HMASTLOCK(rr_lock)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [1:0] resp;
        logic [3:0] split;
        logic [3:0] grant;
        logic [1:0] master;
        logic       mlock;
    } vec_t;

    vec_t tbl [36];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                         input logic [2:0] burst, input logic ready, input logic [1:0] resp,
                         input logic [3:0] split);
        HBUSREQ = req; HLOCK = lock; HTRANS = trans; HBURST = burst;
        HREADY = ready; HRESP = resp; HSPLIT = split;
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_fx(input string tag, input logic [3:0] g, input logic [1:0] m, input logic l);
        chk({tag, " grant"}, int'(fx_grant), int'(g));
        chk({tag, " master"}, int'(fx_master), int'(m));
        chk({tag, " mastlock"}, int'(fx_lock), int'(l));
    endtask

    task automatic do_reset;
        drive(4'b0, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
        HRESET = 1'b1;
        tick;
        HRESET = 1'b0;
    endtask

    logic [3:0] rr_exp_g [7];
    logic [1:0] rr_exp_m [7];

    initial begin
        // burst protection: INCR8 by m0 with BUSY and two wait states, m1 waiting
        tbl = '{
            '{4'b0001,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0001,2'd2,1'b0},
            '{4'b0011,4'b0000,2'd2,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd1,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b0,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b0,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0010,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd3,3'd5,1'b1,2'd0,4'b0000, 4'b0010,2'd1,1'b0},
            // locked hold: m3 locked for 5 transfers while m0 requests
            '{4'b1000,4'b1000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b1000,2'd1,1'b0},
            '{4'b1001,4'b1000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b1000,2'd3,1'b1},
            '{4'b1001,4'b1000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b1000,2'd3,1'b1},
            '{4'b1001,4'b1000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b1000,2'd3,1'b1},
            '{4'b1001,4'b1000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b1000,2'd3,1'b1},
            '{4'b1001,4'b1000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b1000,2'd3,1'b1},
            '{4'b0001,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0001,2'd3,1'b0},
            '{4'b0001,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0001,2'd0,1'b0},
            // split masking of m1, release after 6 cycles, then same-edge set/release
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0010,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b0010,2'd1,1'b0},
            '{4'b0011,4'b0000,2'd0,3'd0,1'b0,2'd3,4'b0000, 4'b0010,2'd1,1'b0},
            '{4'b0011,4'b0000,2'd0,3'd0,1'b1,2'd3,4'b0000, 4'b0001,2'd1,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0100,2'd0,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0010, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0010,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd2,3'd0,1'b1,2'd0,4'b0000, 4'b0010,2'd1,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd3,4'b0010, 4'b0100,2'd1,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0010, 4'b0100,2'd2,1'b0},
            '{4'b0010,4'b0000,2'd0,3'd0,1'b1,2'd0,4'b0000, 4'b0010,2'd2,1'b0}
        };
        rr_exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
        rr_exp_m = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};

        // reset state, held over an edge and after release
        tick;
        chk_fx("reset_held", 4'b0100, 2'd2, 1'b0);
        HRESET = 1'b0;
        #1;
        chk_fx("reset_rel", 4'b0100, 2'd2, 1'b0);
        chk("reset_rr grant", int'(rr_grant), 1);

        for (int i = 0; i < 36; i++) begin
            drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].ready, tbl[i].resp, tbl[i].split);
            tick;
            chk_fx($sformatf("row%0d", i), tbl[i].grant, tbl[i].master, tbl[i].mlock);
        end

        // round-robin rotation with a wait state that must freeze the pointer
        do_reset;
        for (int i = 0; i < 7; i++) begin
            drive(4'b1111, 4'b0, 2'd2, 3'd0, (i == 5) ? 1'b0 : 1'b1, 2'd0, 4'b0);
            tick;
            chk($sformatf("rr%0d grant", i), int'(rr_grant), int'(rr_exp_g[i]));
            chk($sformatf("rr%0d master", i), int'(rr_master), int'(rr_exp_m[i]));
        end

        // async reset in the middle of an INCR16 after beat 5
        do_reset;
        drive(4'b0001, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
        tick;
        drive(4'b0011, 4'b0, 2'd2, 3'd7, 1'b1, 2'd0, 4'b0);
        tick;
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, 4'b0, 2'd3, 3'd7, 1'b1, 2'd0, 4'b0);
            tick;
        end
        chk_fx("incr16_beat5", 4'b0001, 2'd0, 1'b0);
        #1 HRESET = 1'b1;
        #1;
        chk_fx("async_rst", 4'b0100, 2'd2, 1'b0);
        tick;
        HRESET = 1'b0;
        drive(4'b0010, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
        tick;
        chk_fx("post_rst_arb", 4'b0010, 2'd2, 1'b0);
        drive(4'b0010, 4'b0, 2'd2, 3'd3, 1'b1, 2'd0, 4'b0);
        tick;
        chk_fx("post_rst_ns", 4'b0010, 2'd1, 1'b0);
        drive(4'b0001, 4'b0, 2'd3, 3'd3, 1'b1, 2'd0, 4'b0);
        tick;
        chk_fx("post_rst_b2", 4'b0010, 2'd1, 1'b0);
        tick;
        chk_fx("post_rst_b3", 4'b0001, 2'd1, 1'b0);
        tick;
        chk_fx("post_rst_b4", 4'b0001, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_param.md
# ahb_arbiter_param

Parametrised AHB bus arbiter for the multi-master AHB fabric. It generalises the fixed arbitration signal set to NUM_MASTERS masters, with selectable fixed-priority or round-robin policy. It also protects fixed-length bursts, holds locked sequences, and masks SPLIT-responded masters until the slave releases them through HSPLIT. It sits between the master request lines and the address/control mux and decoder.

## Interface
- NUM_MASTERS, 4: masters on the bus; range 2..16.
- DEFAULT_MASTER, 0: index granted when no eligible request exists.
- ARB_MODE, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- MW, $clog2(NUM_MASTERS): derived; width of HMASTER.
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  current address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  in  3  current burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- HREADY  in  1  transfer complete / bus handover qualifier.
- HRESP  in  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
- HSPLIT  in  NUM_MASTERS  per-master split-release pulses.
- HGRANT  out  NUM_MASTERS  one-hot grant; registered.
- HMASTER  out  MW  address-phase owner; registered.
- HMASTLOCK  out  1  current address phase is locked; registered.

## Operation
- Eligible set: HBUSREQ & ~split_mask. If the set is empty, the grant goes to DEFAULT_MASTER.
- Fixed mode: the lowest eligible index wins.
- Round-robin mode: search starts at rr_ptr. On every grant change, rr_ptr becomes the winner index + 1, with modulo wrap.
- States:
  - ARB: free to re-grant.
  - BURST: fixed-length burst in progress.
  - LOCKED: owner holds HLOCK.
- Beat counter beats_left (5 bits):
  - Loaded with len-1 on an accepted NONSEQ (HREADY=1) whose HBURST is fixed-length (4/8/16).
  - Decremented on each accepted SEQ.
  - BUSY and wait states leave it unchanged.
  - SINGLE and INCR never enter BURST.
- Arbitration update (arb_ok) happens on an edge with HREADY=1 and one of:
  - state ARB and HLOCK[granted]=0;
  - state BURST and, after the current edge, beats_left = 1 (grant moves during the last address beat);
  - state LOCKED and HLOCK[granted]=0.
- LOCKED is entered when arb_ok selects a master with HLOCK=1. It is left when HLOCK[granted] deasserts.
- HMASTER and HMASTLOCK load {grant index, HLOCK[grant index]} on every edge where HREADY=1.
- SPLIT/RETRY/ERROR: on an edge with HREADY=1 and HRESP≠OKAY (second response cycle):
  - beats_left clears and state forces ARB; re-arbitration happens the same edge.
  - SPLIT additionally sets split_mask[HMASTER]. That edge's arbitration already excludes HMASTER.
- split_mask[i] clears on any edge where HSPLIT[i]=1. If a set and a clear for the same index occur on the same edge, the set wins.
- DEFAULT_MASTER is never masked: a SPLIT response to it is ignored for masking purposes.

## Timing
- Reset values: HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, split_mask = 0, rr_ptr = 0, state ARB, beats_left = 0.
- HGRANT latency: 1 cycle from a request to a registered grant when arb_ok. HMASTER follows HGRANT on the next HREADY-high edge.
- HREADY=0 freezes HGRANT, HMASTER, HMASTLOCK, rr_ptr, beats_left and state. Only split_mask clears from HSPLIT still act.
- Reset mid-burst or mid-lock: all outputs return to reset values immediately (asynchronous). No partial-burst recovery.
- HGRANT stays one-hot in every cycle; HMASTER always matches the previous HREADY-high grant.

## Structure
- ahb_params_pkg holds:
  - htrans_t, hburst_t and hresp_t encodings;
  - the function burst_len(hburst_t), returning 0 for SINGLE/INCR and 4/8/16 otherwise;
  - the arbiter state enum.
- One sub-module, ahb_arb_prio_sel: combinational masked rotating priority encoder, with inputs req, start_idx and mode and outputs a one-hot and an index. It is instantiated once.

## Test plan
- Reset check: NUM_MASTERS=4, DEFAULT_MASTER=2, no requests, HRESET released → HGRANT=4'b0100, HMASTER=2, HMASTLOCK=0.
- Round-robin rotation: ARB_MODE=1, HBUSREQ=4'b1111 held, SINGLE NONSEQ transfers, HREADY=1 → grants cycle 0,1,2,3,0; HMASTER lags HGRANT by 1 cycle.
- Burst protection: master 0 issues INCR8 while master 1 requests in fixed mode, including one BUSY and two HREADY=0 cycles → HGRANT moves to 1 only on the edge accepting beat 7; HMASTER=1 after beat 8.
- Locked hold: master 3 with HLOCK=1 for 5 transfers; master 0 (higher priority) requests → grant held on 3 with HMASTLOCK=1 for the whole sequence, then moves to 0 on the edge after HLOCK[3] drops.
- Split masking: slave returns SPLIT to master 1 while it still requests → mask set and grant moves to 0. HSPLIT[1] pulsed 6 cycles later → master 1 is re-granted at the next arb_ok. HSPLIT pulsed on the same edge as the SPLIT → mask remains set.
- Async reset mid-INCR16 at beat 5 → outputs at reset values within the reset cycle; after release, beats_left=0 and a new NONSEQ is arbitrated normally.
